fixed_point_subtractor: RTL and testbench

FIXED_POINT_SUBTRACTOR -- requirements
Module: fixed_point_subtractor

---
 rtl/fixed_point_pkg.sv | 14 +
 rtl/fixed_point_subtractor_if.sv | 27 ++
 rtl/fixed_point_saturate.sv | 37 +++
 rtl/fixed_point_subtractor.sv | 94 +++++++++
 tb/tb_fixed_point_subtractor.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fixed_point_pkg.sv
// Shared constants for the fixed-point add/subtract family (signed Q10.5 at default width).
// The subtractor, the adder and the shared saturation stage all draw on these values.
package fixed_point_pkg;

    localparam int WIDTH     = 16;
    localparam int FRAC_BITS = 5;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam int                    CNT_WIDTH = 8;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = 8'hFF;

endpackage

// File: rtl/fixed_point_subtractor_if.sv
// Operand/result bundle for the fixed-point subtractor.
// The master side supplies operands; the slave side returns the registered results.
interface fixed_point_subtractor_if #(
    parameter int WIDTH = fixed_point_pkg::WIDTH
);

    logic                                   enable;
    logic [WIDTH-1:0]                       A;
    logic [WIDTH-1:0]                       B;
    logic                                   clear_count;
    logic [WIDTH-1:0]                       diff;
    logic                                   valid;
    logic                                   ovf_pos;
    logic                                   ovf_neg;
    logic [fixed_point_pkg::CNT_WIDTH-1:0]  sat_count;

    modport master (
        output enable, A, B, clear_count,
        input  diff, valid, ovf_pos, ovf_neg, sat_count
    );

    modport slave (
        input  enable, A, B, clear_count,
        output diff, valid, ovf_pos, ovf_neg, sat_count
    );

endinterface

// File: rtl/fixed_point_saturate.sv
// Clamps a WIDTH+1-bit signed value into WIDTH bits and flags which rail was hit.
// Purely combinational so the adder and subtractor can place it in front of their own result register.
module fixed_point_saturate #(
    parameter int WIDTH = fixed_point_pkg::WIDTH
) (
    input  logic [WIDTH:0]   din,
    output logic [WIDTH-1:0] dout,
    output logic             ovf_pos,
    output logic             ovf_neg
);

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // The two top bits disagree only when the value no longer fits in WIDTH bits.
    always_comb begin
        dout    = din[WIDTH-1:0];
        ovf_pos = 1'b0;
        ovf_neg = 1'b0;
        case (din[WIDTH:WIDTH-1])
            2'b01: begin
                dout    = MAX_VAL;
                ovf_pos = 1'b1;
            end
            2'b10: begin
                dout    = MIN_VAL;
                ovf_neg = 1'b1;
            end
            default: begin
                dout    = din[WIDTH-1:0];
                ovf_pos = 1'b0;
                ovf_neg = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fixed_point_subtractor.sv
// Two-stage saturating signed fixed-point subtractor (diff = A - B) with a sticky saturation counter.
// Stage 1 captures operands; stage 2 subtracts at WIDTH+1 bits, clamps, and registers all outputs.
module fixed_point_subtractor #(
    parameter int WIDTH     = fixed_point_pkg::WIDTH,
    parameter int FRAC_BITS = fixed_point_pkg::FRAC_BITS
) (
    input logic                     clk,
    input logic                     reset,
    fixed_point_subtractor_if.slave bus
);

    import fixed_point_pkg::*;

    if (FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_bad_frac_bits
        $error("FRAC_BITS must lie in the range [0, WIDTH)");
    end

    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic                 en_r;
    logic [WIDTH:0]       diff_wide_s;
    logic [WIDTH-1:0]     sat_s;
    logic                 pos_s;
    logic                 neg_s;
    logic [WIDTH-1:0]     diff_r;
    logic                 valid_r;
    logic                 ovf_pos_r;
    logic                 ovf_neg_r;
    logic [CNT_WIDTH-1:0] sat_count_r;

    // Stage 1: operand capture; the strobe is re-registered every cycle so it drops after one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r  <= {WIDTH{1'b0}};
            b_r  <= {WIDTH{1'b0}};
            en_r <= 1'b0;
        end else begin
            en_r <= bus.enable;
            if (bus.enable) begin
                a_r <= bus.A;
                b_r <= bus.B;
            end
        end
    end

    // One guard bit makes every difference exact, including 0 - 0x8000.
    assign diff_wide_s = {a_r[WIDTH-1], a_r} - {b_r[WIDTH-1], b_r};

    fixed_point_saturate #(
        .WIDTH (WIDTH)
    ) u_saturate (
        .din     (diff_wide_s),
        .dout    (sat_s),
        .ovf_pos (pos_s),
        .ovf_neg (neg_s)
    );

    // Stage 2: result register; diff holds between results while valid and the flags return low.
    always_ff @(posedge clk) begin
        if (reset) begin
            diff_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            ovf_pos_r <= 1'b0;
            ovf_neg_r <= 1'b0;
        end else if (en_r) begin
            diff_r    <= sat_s;
            valid_r   <= 1'b1;
            ovf_pos_r <= pos_s;
            ovf_neg_r <= neg_s;
        end else begin
            valid_r   <= 1'b0;
            ovf_pos_r <= 1'b0;
            ovf_neg_r <= 1'b0;
        end
    end

    // Saturation counter advances alongside the result it counts; clear wins, and it sticks at full scale.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count_r <= {CNT_WIDTH{1'b0}};
        end else if (bus.clear_count) begin
            sat_count_r <= {CNT_WIDTH{1'b0}};
        end else if (en_r && (pos_s || neg_s) && (sat_count_r != CNT_MAX)) begin
            sat_count_r <= sat_count_r + 8'd1;
        end
    end

    assign bus.diff      = diff_r;
    assign bus.valid     = valid_r;
    assign bus.ovf_pos   = ovf_pos_r;
    assign bus.ovf_neg   = ovf_neg_r;
    assign bus.sat_count = sat_count_r;

endmodule

// File: tb/tb_fixed_point_subtractor.sv
// Scoreboard bench for fixed_point_subtractor: stimulus pushes clamped integer differences into a queue,
// an independent monitor pops them whenever valid is seen and also tracks the expected saturation count.
module tb_fixed_point_subtractor;

    import fixed_point_pkg::*;

    typedef struct {
        logic [WIDTH-1:0] d;
        bit               p;
        bit               n;
        int               due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fixed_point_subtractor_if #(.WIDTH(WIDTH)) bus ();

    fixed_point_subtractor #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t             q[$];
    int               n_cmp     = 0;
    int               n_fail    = 0;
    int               cyc       = 0;
    int               exp_cnt   = 0;
    logic [WIDTH-1:0] last_diff = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact integer difference, clamped to the representable signed range.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int due);
        exp_t        e;
        int          d;
        logic [31:0] dv;
        d     = int'($signed(a)) - int'($signed(b));
        e.due = due;
        e.p   = 1'b0;
        e.n   = 1'b0;
        if (d > (2 ** (WIDTH - 1)) - 1) begin
            e.d = SAT_MAX;
            e.p = 1'b1;
        end else if (d < -(2 ** (WIDTH - 1))) begin
            e.d = SAT_MIN;
            e.n = 1'b1;
        end else begin
            dv  = d;
            e.d = dv[WIDTH-1:0];
        end
        return e;
    endfunction

    task automatic step(input bit en, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit clr, input bit rst);
        @(negedge clk);
        reset           = rst;
        bus.enable      = en;
        bus.A           = a;
        bus.B           = b;
        bus.clear_count = clr;
        if (en && !rst) q.push_back(model(a, b, cyc + 2));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    // Monitor: samples the edge's control inputs, then checks outputs 1 time unit later.
    initial begin
        exp_t e;
        bit   r;
        bit   c;
        bit   got_sat;
        forever begin
            @(posedge clk);
            cyc++;
            r = reset;
            c = bus.clear_count;
            #1;
            if (r) begin
                q.delete();
                exp_cnt   = 0;
                last_diff = '0;
                chk("rst_valid", bus.valid, 0);
                chk("rst_diff", bus.diff, 0);
                chk("rst_ovf", {bus.ovf_pos, bus.ovf_neg}, 0);
                chk("rst_sat_count", bus.sat_count, 0);
            end else begin
                got_sat = 1'b0;
                if (bus.valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_valid", bus.valid, 0);
                    end else begin
                        e = q.pop_front();
                        chk("valid_latency", cyc, e.due);
                        chk("diff", bus.diff, e.d);
                        chk("ovf_pos", bus.ovf_pos, e.p);
                        chk("ovf_neg", bus.ovf_neg, e.n);
                        last_diff = e.d;
                        got_sat   = e.p || e.n;
                    end
                end else begin
                    if (q.size() > 0 && q[0].due <= cyc) begin
                        chk("missing_valid", bus.valid, 1);
                        void'(q.pop_front());
                    end
                    chk("diff_hold", bus.diff, last_diff);
                    chk("ovf_idle", {bus.ovf_pos, bus.ovf_neg}, 0);
                end
                if (c) exp_cnt = 0;
                else if (got_sat && exp_cnt < 255) exp_cnt++;
                chk("sat_count", bus.sat_count, exp_cnt);
            end
        end
    end

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.A           = '0;
        bus.B           = '0;
        bus.clear_count = 1'b0;
        repeat (3) step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        idle(2);

        // 260.0 - 2.5, then -30.5 - (-4.25)
        step(1'b1, 16'h2080, 16'h0050, 1'b0, 1'b0); idle(3);
        step(1'b1, 16'hFC30, 16'hFF78, 1'b0, 1'b0); idle(3);
        // 1000.0 - (-513.0) clips high, -512.0 - 1000.0 clips low
        step(1'b1, 16'h7D00, 16'hBFE0, 1'b0, 1'b0); idle(3);
        step(1'b1, 16'hC000, 16'h7D00, 1'b0, 1'b0); idle(3);
        // most-negative operand corners
        step(1'b1, 16'h0000, 16'h8000, 1'b0, 1'b0);
        step(1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0); idle(3);
        // back-to-back 1.0..4.0 minus 0.5
        step(1'b1, 16'h0020, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'h0040, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'h0060, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'h0080, 16'h0010, 1'b0, 1'b0);
        idle(3);
        // reset one cycle after the second enable; an enable held during reset must be ignored
        step(1'b1, 16'h0020, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'h0040, 16'h0010, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 16'h0060, 16'h0010, 1'b0, 1'b1);
        idle(5);
        chk("post_reset_quiet", bus.valid, 0);

        // random traffic: mix of full-range and small operands, sporadic enables and clears
        for (int i = 0; i < 250; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                a = r1[WIDTH-1:0];
                b = r2[WIDTH-1:0];
            end else begin
                a = {{(WIDTH-10){r1[9]}}, r1[9:0]};
                b = {{(WIDTH-10){r2[9]}}, r2[9:0]};
            end
            step($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 15) == 0, 1'b0);
        end
        idle(4);

        // 300 saturating subtractions drive the counter to its ceiling
        for (int i = 0; i < 300; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            step(1'b1, {4'h7, r1[11:0]}, {4'h8, r2[11:0]}, 1'b0, 1'b0);
        end
        idle(4);
        chk("sat_count_full", bus.sat_count, 255);

        // clear lands on the same edge as another saturated result
        step(1'b1, 16'h7FFF, 16'h8000, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        idle(3);
        chk("sat_count_cleared", bus.sat_count, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        chk("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
